sdram_record_master: RTL and testbench

Avalon-MM pipelined-read master that stores and fetches 64-bit search records (packed board/move entries) in the external SDR SDRAM through the system's 16-bit SDRAM controller slave. It sits between the chess search logic and the `sdram_wire` controller. It splits each record into four 16-bit beats, tolerates arbitrary `waitrequest` stalls and read latency, and returns whole records over a simple command/response interface.

---
 rtl/sdram_rec_pkg.sv | 31 +++
 rtl/rec_beat_serdes.sv | 53 +++++
 rtl/sdram_record_master.sv | 139 +++++++++++++
 tb/tb_sdram_record_master.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_rec_pkg.sv
// Shared types and helpers for the SDRAM record master: state encoding,
// record/beat geometry and the record-index to byte-address mapping.
package sdram_rec_pkg;

    localparam int REC_W  = 64;
    localparam int BEAT_W = 16;
    localparam int BEATS  = 4;
    localparam int LANE_W = 2;
    localparam int CALC_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_WAIT,
        DONE
    } rec_state_t;

    typedef logic [BEATS-1:0][BEAT_W-1:0] rec_lanes_t;

    // Byte address of one beat; the caller truncates to the slave width,
    // which gives the required modulo-2^ADDR_W wrap.
    function automatic logic [CALC_W-1:0] rec_byte_addr(
        input logic [CALC_W-1:0] base,
        input logic [CALC_W-1:0] idx,
        input logic [LANE_W-1:0] beat
    );
        return base + (idx << 3) + {{(CALC_W-LANE_W-1){1'b0}}, beat, 1'b0};
    endfunction

endpackage

// File: rtl/rec_beat_serdes.sv
// Splits a 64-bit record into four 16-bit write beats and reassembles
// returned read beats into a record; issue and return counters are independent.
module rec_beat_serdes
    import sdram_rec_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic [REC_W-1:0]  wdata_i,
    input  logic              issue_adv_i,
    input  logic              ret_adv_i,
    input  logic [BEAT_W-1:0] rdata_i,
    output logic [LANE_W-1:0] issue_cnt_o,
    output logic [LANE_W:0]   ret_cnt_o,
    output logic [BEAT_W-1:0] wbeat_o,
    output logic [REC_W-1:0]  rec_o
);

    logic [LANE_W-1:0] issue_q;
    logic [LANE_W:0]   ret_q;
    rec_lanes_t        wdata_q;
    rec_lanes_t        asm_q;

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_q <= '0;
            ret_q   <= '0;
            wdata_q <= '0;
            asm_q   <= '0;
        end else if (clear_i) begin
            issue_q <= '0;
            ret_q   <= '0;
            wdata_q <= wdata_i;
        end else begin
            if (issue_adv_i) begin
                issue_q <= issue_q + 1'b1;
            end
            // The slave returns data in order, so arrival count selects the lane.
            if (ret_adv_i && ret_q != (LANE_W+1)'(BEATS)) begin
                asm_q[ret_q[LANE_W-1:0]] <= rdata_i;
                ret_q                    <= ret_q + 1'b1;
            end
        end
    end

    assign issue_cnt_o = issue_q;
    assign ret_cnt_o   = ret_q;
    assign wbeat_o     = wdata_q[issue_q];
    assign rec_o       = asm_q;

endmodule

// File: rtl/sdram_record_master.sv
// Avalon-MM pipelined-read master moving 64-bit records to/from a 16-bit
// SDRAM controller slave as four beats, with stall tolerance and timeout abort.
module sdram_record_master
    import sdram_rec_pkg::*;
#(
    parameter int                ADDR_W    = 25,
    parameter int                IDX_W     = 20,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                TIMEOUT   = 1024
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [IDX_W-1:0]  cmd_idx,
    input  logic [REC_W-1:0]  cmd_wdata,
    output logic              wr_done,
    output logic              rsp_valid,
    output logic [REC_W-1:0]  rsp_data,
    output logic              err,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [BEAT_W-1:0] avm_writedata,
    output logic [1:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [BEAT_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    rec_state_t        state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              is_wr_q;
    logic [IDX_W-1:0]  idx_q;
    logic [REC_W-1:0]  rsp_q;

    logic              cmd_accept;
    logic              beat_acc;
    logic              data_beat;
    logic              counting;
    logic              expire;
    logic              last_issue;
    logic              all_ret;
    logic [LANE_W-1:0] issue_cnt;
    logic [LANE_W:0]   ret_cnt;
    logic [BEAT_W-1:0] wbeat;
    logic [REC_W-1:0]  rec_asm;

    rec_beat_serdes u_serdes (
        .clk         (clk_clk),
        .rst_n       (reset_reset_n),
        .clear_i     (cmd_accept),
        .wdata_i     (cmd_wdata),
        .issue_adv_i (beat_acc),
        .ret_adv_i   (data_beat),
        .rdata_i     (avm_readdata),
        .issue_cnt_o (issue_cnt),
        .ret_cnt_o   (ret_cnt),
        .wbeat_o     (wbeat),
        .rec_o       (rec_asm)
    );

    assign cmd_accept = cmd_valid && cmd_ready;
    assign beat_acc   = (avm_read || avm_write) && !avm_waitrequest;
    // Read data outside a fetch is stray and must not touch the lanes.
    assign data_beat  = avm_readdatavalid && (state_q == RD_ISSUE || state_q == RD_WAIT);
    assign counting   = (state_q != IDLE) && (state_q != DONE);
    assign expire     = counting && !beat_acc && !data_beat && (tmo_q == TMO_W'(TIMEOUT - 1));
    assign last_issue = (issue_cnt == LANE_W'(BEATS - 1));
    assign all_ret    = (ret_cnt == (LANE_W+1)'(BEATS)) ||
                        (ret_cnt == (LANE_W+1)'(BEATS - 1) && data_beat);

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            is_wr_q <= 1'b0;
            idx_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            if (cmd_accept) begin
                is_wr_q <= cmd_write;
                idx_q   <= cmd_idx;
            end
            if (state_q == DONE && !is_wr_q) begin
                rsp_q <= rec_asm;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        tmo_d   = '0;
        if (counting && !beat_acc && !data_beat) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
        unique case (state_q)
            IDLE:     if (cmd_accept) state_d = cmd_write ? WR : RD_ISSUE;
            WR:       if (beat_acc && last_issue) state_d = DONE;
            RD_ISSUE: if (beat_acc && last_issue) state_d = all_ret ? DONE : RD_WAIT;
            RD_WAIT:  if (all_ret) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (expire) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        cmd_ready      = (state_q == IDLE);
        wr_done        = (state_q == DONE) && is_wr_q;
        rsp_valid      = (state_q == DONE) && !is_wr_q;
        err            = expire;
        avm_write      = (state_q == WR);
        avm_read       = (state_q == RD_ISSUE);
        avm_byteenable = 2'b00;
        avm_address    = '0;
        avm_writedata  = '0;
        // Address and data come straight from the issue counter, which only
        // moves on accept, so they stay stable through waitrequest.
        if (avm_read || avm_write) begin
            avm_byteenable = 2'b11;
            avm_address    = ADDR_W'(rec_byte_addr(CALC_W'(BASE_ADDR), CALC_W'(idx_q), issue_cnt));
        end
        if (avm_write) begin
            avm_writedata = wbeat;
        end
        rsp_data = rsp_valid ? rec_asm : rsp_q;
    end

endmodule

// File: tb/tb_sdram_record_master.sv
// Directed bench for sdram_record_master: a small Avalon slave model with
// programmable latency, stalls and dropped beats; cycle 0 is the accept cycle.
module tb_sdram_record_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_write;
    logic [19:0] cmd_idx;
    logic [63:0] cmd_wdata;
    logic        avm_waitrequest;
    logic [15:0] avm_readdata;
    logic        avm_readdatavalid;

    logic        cmd_ready, wr_done, rsp_valid, err;
    logic [63:0] rsp_data;
    logic [24:0] avm_address;
    logic        avm_read, avm_write;
    logic [15:0] avm_writedata;
    logic [1:0]  avm_byteenable;

    logic        cmd_ready_1, wr_done_1, rsp_valid_1, err_1;
    logic [63:0] rsp_data_1;
    logic [24:0] avm_address_1;
    logic        avm_read_1, avm_write_1;
    logic [15:0] avm_writedata_1;
    logic [1:0]  avm_byteenable_1;

    sdram_record_master #(.ADDR_W(25), .IDX_W(20), .BASE_ADDR(25'h0), .TIMEOUT(16)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_idx(cmd_idx), .cmd_wdata(cmd_wdata),
        .wr_done(wr_done), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid)
    );

    sdram_record_master #(.ADDR_W(25), .IDX_W(20), .BASE_ADDR(25'h1FFFFF8), .TIMEOUT(16)) dut_hi (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_1), .cmd_write(cmd_write),
        .cmd_idx(cmd_idx), .cmd_wdata(cmd_wdata),
        .wr_done(wr_done_1), .rsp_valid(rsp_valid_1), .rsp_data(rsp_data_1), .err(err_1),
        .avm_address(avm_address_1), .avm_read(avm_read_1), .avm_write(avm_write_1),
        .avm_writedata(avm_writedata_1), .avm_byteenable(avm_byteenable_1),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Slave model state
    typedef struct {
        int          due;
        logic [15:0] d;
    } rd_t;

    logic [15:0] mem [logic [24:0]];
    rd_t         pend[$];
    int          cyc = 0;
    int          lat = 1;
    int          stall_beat = -1;
    int          stall_left = 0;
    int          beat_no = 0;
    bit          drop3 = 1'b0;
    bit          stray = 1'b0;
    logic [15:0] stray_data = 16'h0;
    int          wr_seen = 0;
    int          rsp_seen = 0;
    int          err_seen = 0;

    function automatic logic [15:0] rd(input logic [24:0] a);
        return mem.exists(a) ? mem[a] : 16'hDEAD;
    endfunction

    // One clock: drive slave inputs for the new cycle, then log accepts and pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        cmd_valid         = 1'b0;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 16'h0;
        if ((avm_read || avm_write) && beat_no == stall_beat && stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
        end
        if (pend.size() > 0 && pend[0].due == cyc) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = pend[0].d;
            void'(pend.pop_front());
        end
        if (stray) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = stray_data;
        end
        #1;
        if ((avm_read || avm_write) && !avm_waitrequest) begin
            if (avm_write) mem[avm_address] = avm_writedata;
            else if (!(drop3 && beat_no == 3)) pend.push_back('{due: cyc + lat, d: rd(avm_address)});
            beat_no++;
        end
        if (wr_done)   wr_seen++;
        if (rsp_valid) rsp_seen++;
        if (err)       err_seen++;
    endtask

    task automatic start_cmd(input logic wr, input logic [19:0] idx, input logic [63:0] data);
        tick();
        cyc        = 0;
        beat_no    = 0;
        pend.delete();
        check("cmd_ready_before_accept", 64'(cmd_ready), 64'd1);
        cmd_valid  = 1'b1;
        cmd_write  = wr;
        cmd_idx    = idx;
        cmd_wdata  = data;
    endtask

    // which: 0 = wr_done, 1 = rsp_valid, 2 = err; at = -1 if the budget expires
    task automatic wait_evt(input int which, output int at);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if ((which == 0 && wr_done) || (which == 1 && rsp_valid) || (which == 2 && err)) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] rec_a;
        logic [63:0] rec_b;
        int          at;
        int          snap;

        rec_a = 64'h0123_4567_89AB_CDEF;
        rec_b = 64'hFEDC_BA98_7654_3210;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_idx = '0; cmd_wdata = '0;
        avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_rsp_data", rsp_data, 64'h0);
        check("rst_strobes", {61'd0, avm_read, avm_write, wr_done}, 64'h0);
        check("rst_be_addr", {37'd0, avm_byteenable, avm_address}, 64'h0);
        check("rst_pulses", {62'd0, rsp_valid, err}, 64'h0);

        // Store idx 5: beats to 0x28..0x2E, little-endian lanes, wr_done in cycle 5.
        start_cmd(1'b1, 20'd5, rec_a);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("st_write_c%0d", k + 1), 64'(avm_write), 64'd1);
            check($sformatf("st_addr_c%0d", k + 1), 64'(avm_address), 64'(25'h28 + 25'(2 * k)));
            check($sformatf("st_data_c%0d", k + 1), 64'(avm_writedata), 64'(rec_a[16*k +: 16]));
            check($sformatf("st_be_c%0d", k + 1), 64'(avm_byteenable), 64'd3);
        end
        tick();
        check("st_wr_done_c5", 64'(wr_done), 64'd1);
        check("st_strobes_c5", {62'd0, avm_write, avm_read}, 64'h0);
        tick();
        check("st_ready_c6", 64'(cmd_ready), 64'd1);
        check("st_wr_done_c6", 64'(wr_done), 64'd0);

        // Fetch idx 5, L=3, beat 1 stalled for two cycles.
        lat = 3; stall_beat = 1; stall_left = 2;
        start_cmd(1'b0, 20'd5, 64'h0);
        tick();
        check("f1_addr_c1", 64'(avm_address), 64'h28);
        tick();
        check("f1_wait_c2", 64'(avm_waitrequest), 64'd1);
        check("f1_addr_c2", 64'(avm_address), 64'h2A);
        tick();
        check("f1_addr_c3", {47'd0, avm_read, avm_address}, {47'd0, 1'b1, 25'h2A});
        tick();
        check("f1_addr_c4", 64'(avm_address), 64'h2A);
        tick();
        check("f1_addr_c5", 64'(avm_address), 64'h2C);
        tick();
        check("f1_addr_c6", 64'(avm_address), 64'h2E);
        wait_evt(1, at);
        check("f1_rsp_cycle", 64'(at), 64'd10);
        check("f1_rsp_data", rsp_data, rec_a);
        stall_beat = -1;

        // Store idx 2, then fetch it back with L=1 (data overlaps issue).
        start_cmd(1'b1, 20'd2, rec_b);
        wait_evt(0, at);
        check("st2_done_cycle", 64'(at), 64'd5);
        lat = 1;
        start_cmd(1'b0, 20'd2, 64'h0);
        wait_evt(1, at);
        check("f2_rsp_cycle", 64'(at), 64'd6);
        check("f2_rsp_data", rsp_data, rec_b);
        tick();
        check("f2_rsp_held", rsp_data, rec_b);

        // Timeout: 4th data beat withheld; data lands in cycles 4,5,6, err in 22.
        lat = 3; drop3 = 1'b1;
        snap = rsp_seen;
        start_cmd(1'b0, 20'd5, 64'h0);
        wait_evt(2, at);
        check("to_err_cycle", 64'(at), 64'd22);
        tick();
        check("to_ready_after", 64'(cmd_ready), 64'd1);
        check("to_err_one_cycle", 64'(err), 64'd0);
        check("to_no_rsp", 64'(rsp_seen - snap), 64'd0);
        check("to_rsp_data_held", rsp_data, rec_b);
        drop3 = 1'b0;

        // Reset during write beat 2.
        snap = wr_seen;
        start_cmd(1'b1, 20'd7, 64'h1111_2222_3333_4444);
        tick();
        tick();
        tick();
        check("rs_beat2_addr", 64'(avm_address), 64'h3C);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rs_strobes_off", {37'd0, avm_write, avm_read, avm_byteenable, avm_address}, 64'h0);
        check("rs_ready", 64'(cmd_ready), 64'd1);
        repeat (6) tick();
        check("rs_no_wr_done", 64'(wr_seen - snap), 64'd0);
        check("rs_rsp_data_cleared", rsp_data, 64'h0);

        // Stray readdatavalid in IDLE, then max-index fetch with address wrap.
        snap = rsp_seen;
        stray = 1'b1; stray_data = 16'hBEEF;
        tick();
        tick();
        stray = 1'b0;
        check("sy_no_rsp", 64'(rsp_seen - snap), 64'd0);
        check("sy_rsp_data", rsp_data, 64'h0);
        lat = 1;
        start_cmd(1'b0, 20'hFFFFF, 64'h0);
        tick();
        check("wr_addr_hi_b0", 64'(avm_address_1), 64'h7FFFF0);
        check("wr_addr_lo_b0", 64'(avm_address), 64'h7FFFF8);
        tick();
        check("wr_addr_hi_b1", 64'(avm_address_1), 64'h7FFFF2);
        wait_evt(1, at);
        check("wr_rsp_cycle", 64'(at), 64'd6);
        check("wr_rsp_data", rsp_data, 64'hDEAD_DEAD_DEAD_DEAD);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
